// File: rtl/kairo_dm_pkg.sv
// Shared DMI address map, cmderr codes, AR sequencer states and the
// abstract-command bitfield layout for the kairo debug module.
package kairo_dm_pkg;

    localparam logic [6:0] DMI_DATA0        = 7'h04;
    localparam logic [6:0] DMI_DATA1        = 7'h05;
    localparam logic [6:0] DMI_DMCONTROL    = 7'h10;
    localparam logic [6:0] DMI_DMSTATUS     = 7'h11;
    localparam logic [6:0] DMI_ABSTRACTCS   = 7'h16;
    localparam logic [6:0] DMI_COMMAND      = 7'h17;
    localparam logic [6:0] DMI_ABSTRACTAUTO = 7'h18;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_EXCEPT     = 3'd3,
        CMDERR_HALTRESUME = 3'd4
    } cmderr_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } ar_state_e;

    typedef struct packed {
        logic [7:0]  cmdtype;
        logic        rsvd;
        logic [2:0]  aarsize;
        logic        postinc;
        logic        postexec;
        logic        transfer;
        logic        write;
        logic [15:0] regno;
    } command_t;

    // CSRs 0x0000-0x0FFF and GPRs 0x1000-0x101F form one contiguous window.
    function automatic logic regno_ok(input logic [15:0] regno);
        return regno <= 16'h101F;
    endfunction

endpackage

// File: rtl/kairo_dm_ar_fsm.sv
// Abstract-register access sequencer: one AR_EN strobe, AR_LATENCY wait
// cycles, capture of read data, then a postincrement slot before going idle.
module kairo_dm_ar_fsm
    import kairo_dm_pkg::*;
#(
    parameter int AR_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_write,
    input  logic [15:0] i_regno,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_cap_en,
    output logic        o_incr,
    output logic        o_ar_en,
    output logic        o_ar_wr,
    output logic [15:0] o_ar_ad,
    output logic [31:0] o_ar_di
);

    localparam int WCW = (AR_LATENCY > 1) ? $clog2(AR_LATENCY) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(AR_LATENCY - 1);

    ar_state_e      r_state;
    logic [WCW-1:0] r_wcnt;
    logic           r_ar_en;
    logic           r_ar_wr;
    logic [15:0]    r_ar_ad;
    logic [31:0]    r_ar_di;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
            r_ar_en <= 1'b0;
            r_ar_wr <= 1'b0;
            r_ar_ad <= '0;
            r_ar_di <= '0;
        end else begin
            r_ar_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_ISSUE;
                        r_ar_en <= 1'b1;
                        r_ar_wr <= i_write;
                        r_ar_ad <= i_regno;
                        r_ar_di <= i_wdata;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                    r_wcnt  <= '0;
                end
                ST_WAIT: begin
                    if (r_wcnt == WLAST) r_state <= ST_CAPTURE;
                    else                 r_wcnt  <= r_wcnt + 1'b1;
                end
                ST_CAPTURE: r_state <= ST_DONE;
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ar_wr <= 1'b0;
                    r_ar_ad <= '0;
                    r_ar_di <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Responder data is valid on the last WAIT cycle; the top loads data0 then.
    assign o_busy   = (r_state != ST_IDLE);
    assign o_cap_en = (r_state == ST_WAIT) && (r_wcnt == WLAST) && !r_ar_wr;
    assign o_incr   = (r_state == ST_CAPTURE);
    assign o_ar_en  = r_ar_en;
    assign o_ar_wr  = r_ar_wr;
    assign o_ar_ad  = r_ar_ad;
    assign o_ar_di  = r_ar_di;

endmodule

// File: rtl/kairo_dm_abstract.sv
// Debug-module DMI register file and abstract "access register" command front end.
// KAIRO_DM_AUTOEXEC_EN adds abstractauto (0x18) with autoexecdata0.
module kairo_dm_abstract
    import kairo_dm_pkg::*;
#(
    parameter int AR_LATENCY = 1,
    parameter int DM_VERSION = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DMI_EN,
    input  logic        DMI_WR,
    input  logic [6:0]  DMI_AD,
    input  logic [31:0] DMI_DI,
    output logic [31:0] DMI_DO,
    input  logic        HALTED,
    output logic        HALTREQ,
    output logic        RESUMEREQ,
    output logic        AR_EN,
    output logic        AR_WR,
    output logic [15:0] AR_AD,
    output logic [31:0] AR_DI,
    input  logic [31:0] AR_DO
);

    logic [31:0] r_data0;
    logic [31:0] r_data1;
    command_t    r_command;
    cmderr_e     r_cmderr;
    logic        r_dmactive;
    logic        r_haltreq;
    logic        r_resumereq;
    logic        r_resumeack;
    logic        r_resume_pend;
    logic [31:0] r_dmi_do;
`ifdef KAIRO_DM_AUTOEXEC_EN
    logic        r_autoexec;
`endif

    logic        w_rd;
    logic        w_wr;
    logic        w_busy;
    logic        w_err_free;
    logic        w_d0_acc;
    logic        w_busy_err;
    logic        w_cmd_issue;
    logic        w_auto;
    logic        w_exec;
    command_t    w_exec_cmd;
    cmderr_e     w_exec_err;
    logic        w_start;
    logic        w_skip;
    logic [31:0] w_ar_wdata;
    logic        w_cap_en;
    logic        w_incr;
    logic [31:0] w_rdata;
    logic [31:0] w_dmstatus;

    assign w_rd        = DMI_EN && !DMI_WR;
    assign w_wr        = DMI_EN && DMI_WR;
    assign w_err_free  = (r_cmderr == CMDERR_NONE);
    assign w_d0_acc    = DMI_EN && (DMI_AD == DMI_DATA0);
    assign w_cmd_issue = r_dmactive && w_wr && (DMI_AD == DMI_COMMAND) && !w_busy && w_err_free;

`ifdef KAIRO_DM_AUTOEXEC_EN
    assign w_auto = r_dmactive && r_autoexec && w_d0_acc && !w_busy && w_err_free;
`else
    assign w_auto = 1'b0;
`endif

    assign w_exec     = w_cmd_issue || w_auto;
    assign w_ar_wdata = (w_wr && DMI_AD == DMI_DATA0) ? DMI_DI : r_data0;

    always_comb begin
        w_busy_err = 1'b0;
        if (DMI_EN && w_busy) begin
            if (DMI_WR) w_busy_err = DMI_AD inside {DMI_DATA0, DMI_DATA1, DMI_ABSTRACTCS, DMI_COMMAND};
            else        w_busy_err = (DMI_AD == DMI_DATA0);
        end
    end

    // Checks in priority order; transfer=0 completes at once without an AR cycle.
    always_comb begin
        w_exec_cmd = w_cmd_issue ? command_t'(DMI_DI) : r_command;
        w_exec_err = CMDERR_NONE;
        w_start    = 1'b0;
        w_skip     = 1'b0;
        if (w_exec) begin
            if (w_exec_cmd.cmdtype != 8'd0 || w_exec_cmd.aarsize != 3'd2 || w_exec_cmd.postexec)
                w_exec_err = CMDERR_NOTSUP;
            else if (!HALTED)
                w_exec_err = CMDERR_HALTRESUME;
            else if (!w_exec_cmd.transfer)
                w_skip = 1'b1;
            else if (!regno_ok(w_exec_cmd.regno))
                w_exec_err = CMDERR_EXCEPT;
            else
                w_start = 1'b1;
        end
    end

    always_comb begin
        w_dmstatus        = '0;
        w_dmstatus[17:16] = {2{r_resumeack}};
        w_dmstatus[11:10] = {2{!HALTED}};
        w_dmstatus[9:8]   = {2{HALTED}};
        w_dmstatus[7]     = 1'b1;
        w_dmstatus[3:0]   = 4'(DM_VERSION);
    end

    always_comb begin
        w_rdata = '0;
        case (DMI_AD)
            DMI_DATA0:      w_rdata = r_data0;
            DMI_DATA1:      w_rdata = r_data1;
            DMI_DMCONTROL:  w_rdata = {r_haltreq, 30'b0, r_dmactive};
            DMI_DMSTATUS:   w_rdata = w_dmstatus;
            DMI_ABSTRACTCS: w_rdata = {19'b0, w_busy, 1'b0, r_cmderr, 4'b0, 4'd2};
`ifdef KAIRO_DM_AUTOEXEC_EN
            DMI_ABSTRACTAUTO: w_rdata = {31'b0, r_autoexec};
`endif
            default:        w_rdata = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_data0       <= '0;
            r_data1       <= '0;
            r_command     <= '0;
            r_cmderr      <= CMDERR_NONE;
            r_dmactive    <= 1'b0;
            r_haltreq     <= 1'b0;
            r_resumereq   <= 1'b0;
            r_resumeack   <= 1'b0;
            r_resume_pend <= 1'b0;
            r_dmi_do      <= '0;
`ifdef KAIRO_DM_AUTOEXEC_EN
            r_autoexec    <= 1'b0;
`endif
        end else begin
            r_resumereq <= 1'b0;
            r_dmi_do    <= w_rd ? w_rdata : '0;
            if (w_wr && DMI_AD == DMI_DMCONTROL) r_dmactive <= DMI_DI[0];
            if (!r_dmactive) begin
                r_data0       <= '0;
                r_data1       <= '0;
                r_command     <= '0;
                r_cmderr      <= CMDERR_NONE;
                r_haltreq     <= 1'b0;
                r_resumeack   <= 1'b0;
                r_resume_pend <= 1'b0;
`ifdef KAIRO_DM_AUTOEXEC_EN
                r_autoexec    <= 1'b0;
`endif
            end else begin
                if (r_resume_pend && !r_resumereq && !HALTED) begin
                    r_resumeack   <= 1'b1;
                    r_resume_pend <= 1'b0;
                end
                if (w_wr && !w_busy) begin
                    case (DMI_AD)
                        DMI_DATA0:      r_data0  <= DMI_DI;
                        DMI_DATA1:      r_data1  <= DMI_DI;
                        DMI_ABSTRACTCS: r_cmderr <= cmderr_e'(r_cmderr & ~DMI_DI[10:8]);
`ifdef KAIRO_DM_AUTOEXEC_EN
                        DMI_ABSTRACTAUTO: r_autoexec <= DMI_DI[0];
`endif
                        default: ;
                    endcase
                end
                if (w_wr && DMI_AD == DMI_DMCONTROL) begin
                    r_haltreq <= DMI_DI[31];
                    if (DMI_DI[30]) begin
                        r_resumereq   <= 1'b1;
                        r_resumeack   <= 1'b0;
                        r_resume_pend <= 1'b1;
                    end
                end
                if (w_busy_err && w_err_free) r_cmderr <= CMDERR_BUSY;
                if (w_exec) begin
                    if (w_cmd_issue) r_command <= w_exec_cmd;
                    if (w_exec_err != CMDERR_NONE)
                        r_cmderr <= w_exec_err;
                    else if (w_skip && w_exec_cmd.postinc)
                        r_command.regno <= w_exec_cmd.regno + 16'd1;
                end
                if (w_cap_en) r_data0 <= AR_DO;
                if (w_incr && r_command.postinc) r_command.regno <= r_command.regno + 16'd1;
            end
        end
    end

    kairo_dm_ar_fsm #(
        .AR_LATENCY(AR_LATENCY)
    ) u_ar_fsm (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_start (w_start),
        .i_write (w_exec_cmd.write),
        .i_regno (w_exec_cmd.regno),
        .i_wdata (w_ar_wdata),
        .o_busy  (w_busy),
        .o_cap_en(w_cap_en),
        .o_incr  (w_incr),
        .o_ar_en (AR_EN),
        .o_ar_wr (AR_WR),
        .o_ar_ad (AR_AD),
        .o_ar_di (AR_DI)
    );

    assign DMI_DO    = r_dmi_do;
    assign HALTREQ   = r_haltreq && r_dmactive;
    assign RESUMEREQ = r_resumereq;

endmodule

// File: tb/tb_kairo_dm_abstract.sv
// Directed bench for kairo_dm_abstract: DMI register map, abstract command
// sequencing against a one-cycle registered responder, and error paths.
module tb_kairo_dm_abstract;
    import kairo_dm_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        DMI_EN = 1'b0;
    logic        DMI_WR = 1'b0;
    logic [6:0]  DMI_AD = '0;
    logic [31:0] DMI_DI = '0;
    logic [31:0] DMI_DO;
    logic        HALTED = 1'b1;
    logic        HALTREQ;
    logic        RESUMEREQ;
    logic        AR_EN;
    logic        AR_WR;
    logic [15:0] AR_AD;
    logic [31:0] AR_DI;
    logic [31:0] AR_DO = '0;

    logic [31:0] rsp_val = '0;
    int          ar_cnt = 0;
    int          rr_cnt = 0;
    logic [15:0] ar_ad_l = '0;
    logic        ar_wr_l = 1'b0;
    logic [31:0] ar_di_l = '0;

    int nvec = 0;
    int nerr = 0;

    kairo_dm_abstract #(.AR_LATENCY(1), .DM_VERSION(2)) dut (
        .CLK(CLK), .RST(RST), .DMI_EN(DMI_EN), .DMI_WR(DMI_WR), .DMI_AD(DMI_AD),
        .DMI_DI(DMI_DI), .DMI_DO(DMI_DO), .HALTED(HALTED), .HALTREQ(HALTREQ),
        .RESUMEREQ(RESUMEREQ), .AR_EN(AR_EN), .AR_WR(AR_WR), .AR_AD(AR_AD),
        .AR_DI(AR_DI), .AR_DO(AR_DO)
    );

    always #5 CLK = ~CLK;

    // Registered responder plus AR / resume activity monitor.
    always @(posedge CLK) begin
        if (AR_EN && !AR_WR) AR_DO <= rsp_val;
        if (AR_EN) begin
            ar_cnt  <= ar_cnt + 1;
            ar_ad_l <= AR_AD;
            ar_wr_l <= AR_WR;
            ar_di_l <= AR_DI;
        end
        if (RESUMEREQ) rr_cnt <= rr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic dmi_wr(input logic [6:0] a, input logic [31:0] d);
        @(negedge CLK);
        DMI_EN = 1'b1; DMI_WR = 1'b1; DMI_AD = a; DMI_DI = d;
        @(negedge CLK);
        DMI_EN = 1'b0; DMI_WR = 1'b0;
    endtask

    task automatic dmi_rd(input logic [6:0] a, output logic [31:0] d);
        @(negedge CLK);
        DMI_EN = 1'b1; DMI_WR = 1'b0; DMI_AD = a;
        @(negedge CLK);
        DMI_EN = 1'b0;
        d = DMI_DO;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        logic [31:0] rd;
        logic [4:0]  hist;

        idle(3);
        chk("rst_dmi_do", DMI_DO, 32'h0);
        chk("rst_haltreq", {31'b0, HALTREQ}, 32'h0);
        chk("rst_resumereq", {31'b0, RESUMEREQ}, 32'h0);
        chk("rst_ar_en", {31'b0, AR_EN}, 32'h0);
        chk("rst_ar_ad", {16'b0, AR_AD}, 32'h0);
        RST = 1'b0;
        dmi_rd(DMI_ABSTRACTCS, rd); chk("rst_abstractcs", rd, 32'h0000_0002);
        dmi_rd(DMI_DMSTATUS, rd);   chk("dmstatus_halted", rd, 32'h0000_0382);

        dmi_wr(DMI_DMCONTROL, 32'h8000_0000);
        chk("haltreq_inactive", {31'b0, HALTREQ}, 32'h0);
        dmi_wr(DMI_DMCONTROL, 32'h0000_0001);
        dmi_wr(DMI_DMCONTROL, 32'h8000_0001);
        chk("haltreq_active", {31'b0, HALTREQ}, 32'h1);
        dmi_rd(DMI_DMCONTROL, rd); chk("dmcontrol_rd", rd, 32'h8000_0001);

        // CSR write: busy visible for exactly four cycles after the command strobe.
        dmi_wr(DMI_DATA0, 32'hDEAD_BEEF);
        dmi_wr(DMI_COMMAND, 32'h0023_0300);
        DMI_EN = 1'b1; DMI_WR = 1'b0; DMI_AD = DMI_ABSTRACTCS;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            hist[4-i] = DMI_DO[12];
        end
        DMI_EN = 1'b0;
        chk("busy_trace", {27'b0, hist}, 32'h0000_001E);
        chk("csrw_ar_cnt", ar_cnt, 32'd1);
        chk("csrw_ar_ad", {16'b0, ar_ad_l}, 32'h0000_0300);
        chk("csrw_ar_wr", {31'b0, ar_wr_l}, 32'h1);
        chk("csrw_ar_di", ar_di_l, 32'hDEAD_BEEF);
        chk("idle_ar_ad", {16'b0, AR_AD}, 32'h0);
        dmi_rd(DMI_DATA0, rd); chk("csrw_data0_kept", rd, 32'hDEAD_BEEF);

        rsp_val = 32'h1234_5678;
        dmi_wr(DMI_COMMAND, 32'h0022_1008);
        idle(6);
        dmi_rd(DMI_DATA0, rd);      chk("gprr_data0", rd, 32'h1234_5678);
        dmi_rd(DMI_ABSTRACTCS, rd); chk("gprr_abstractcs", rd, 32'h0000_0002);
        chk("gprr_ar_cnt", ar_cnt, 32'd2);
        chk("gprr_ar_ad", {16'b0, ar_ad_l}, 32'h0000_1008);
        chk("gprr_ar_wr", {31'b0, ar_wr_l}, 32'h0);

        HALTED = 1'b0;
        dmi_wr(DMI_COMMAND, 32'h0022_1008);
        idle(4);
        dmi_rd(DMI_ABSTRACTCS, rd); chk("running_cmderr4", rd, 32'h0000_0402);
        chk("running_no_ar", ar_cnt, 32'd2);
        dmi_wr(DMI_ABSTRACTCS, 32'h0000_0700);
        dmi_rd(DMI_ABSTRACTCS, rd); chk("w1c_clear", rd, 32'h0000_0002);
        HALTED = 1'b1;

        // Back-to-back command strobes: second one is a busy error, first completes.
        rsp_val = 32'hA5A5_A5A5;
        @(negedge CLK);
        DMI_EN = 1'b1; DMI_WR = 1'b1; DMI_AD = DMI_COMMAND; DMI_DI = 32'h0022_1009;
        @(negedge CLK);
        @(negedge CLK);
        DMI_EN = 1'b0; DMI_WR = 1'b0;
        idle(6);
        dmi_rd(DMI_ABSTRACTCS, rd); chk("b2b_cmderr1", rd, 32'h0000_0102);
        dmi_rd(DMI_DATA0, rd);      chk("b2b_data0", rd, 32'hA5A5_A5A5);
        chk("b2b_ar_cnt", ar_cnt, 32'd3);
        dmi_wr(DMI_ABSTRACTCS, 32'h0000_0100);

        dmi_wr(DMI_COMMAND, 32'h0032_1008);
        idle(4);
        dmi_rd(DMI_ABSTRACTCS, rd); chk("aarsize3_cmderr2", rd, 32'h0000_0202);
        chk("aarsize3_no_ar", ar_cnt, 32'd3);
        dmi_wr(DMI_ABSTRACTCS, 32'h0000_0700);

        dmi_wr(DMI_COMMAND, 32'h0022_1020);
        idle(4);
        dmi_rd(DMI_ABSTRACTCS, rd); chk("regno_oob_cmderr3", rd, 32'h0000_0302);
        chk("regno_oob_no_ar", ar_cnt, 32'd3);
        dmi_wr(DMI_ABSTRACTCS, 32'h0000_0700);

        rsp_val = 32'h0BAD_F00D;
        dmi_wr(DMI_COMMAND, 32'h0022_101F);
        idle(6);
        chk("regno_edge_ar_cnt", ar_cnt, 32'd4);
        chk("regno_edge_ar_ad", {16'b0, ar_ad_l}, 32'h0000_101F);
        dmi_rd(DMI_DATA0, rd); chk("regno_edge_data0", rd, 32'h0BAD_F00D);

        dmi_wr(DMI_COMMAND, 32'h0020_1234);
        idle(6);
        chk("notransfer_no_ar", ar_cnt, 32'd4);
        dmi_rd(DMI_ABSTRACTCS, rd); chk("notransfer_cmderr0", rd, 32'h0000_0002);

        // data0 read during a command returns the old value and flags busy.
        rsp_val = 32'h55AA_55AA;
        dmi_wr(DMI_COMMAND, 32'h0022_1008);
        DMI_EN = 1'b1; DMI_WR = 1'b0; DMI_AD = DMI_DATA0;
        @(negedge CLK);
        DMI_EN = 1'b0;
        chk("busy_rd_data0_old", DMI_DO, 32'h0BAD_F00D);
        idle(6);
        dmi_rd(DMI_ABSTRACTCS, rd); chk("busy_rd_cmderr1", rd, 32'h0000_0102);
        dmi_rd(DMI_DATA0, rd);      chk("busy_rd_capture", rd, 32'h55AA_55AA);
        chk("busy_rd_ar_cnt", ar_cnt, 32'd5);
        dmi_wr(DMI_ABSTRACTCS, 32'h0000_0700);

        dmi_wr(DMI_DMCONTROL, 32'hC000_0001);
        idle(2);
        chk("resumereq_pulses", rr_cnt, 32'd1);
        dmi_rd(DMI_DMCONTROL, rd); chk("resumereq_reads0", rd, 32'h8000_0001);
        dmi_rd(DMI_DMSTATUS, rd);  chk("resumeack_clear", rd, 32'h0000_0382);
        HALTED = 1'b0;
        idle(1);
        dmi_rd(DMI_DMSTATUS, rd);  chk("resumeack_set", rd, 32'h0003_0C82);
        HALTED = 1'b1;
        dmi_rd(DMI_DMSTATUS, rd);  chk("resumeack_hold", rd, 32'h0003_0382);

        dmi_rd(7'h20, rd);       chk("unmapped_rd", rd, 32'h0);
        dmi_rd(DMI_COMMAND, rd); chk("command_wo", rd, 32'h0);
        dmi_wr(DMI_DATA1, 32'h1357_9BDF);
        dmi_rd(DMI_DATA1, rd);   chk("data1_rw", rd, 32'h1357_9BDF);

`ifdef KAIRO_DM_AUTOEXEC_EN
        dmi_wr(DMI_ABSTRACTAUTO, 32'h1);
        dmi_rd(DMI_ABSTRACTAUTO, rd); chk("autoexec_rd", rd, 32'h1);
        dmi_wr(DMI_COMMAND, 32'h002A_1000);
        idle(6);
        chk("postinc_run0_cnt", ar_cnt, 32'd6);
        chk("postinc_run0_ad", {16'b0, ar_ad_l}, 32'h0000_1000);
        for (int k = 1; k <= 3; k++) begin
            dmi_rd(DMI_DATA0, rd);
            idle(6);
            chk("autoexec_cnt", ar_cnt, 32'(6 + k));
            chk("autoexec_ad", {16'b0, ar_ad_l}, 32'h0000_1000 + 32'(k));
        end
`else
        dmi_wr(DMI_ABSTRACTAUTO, 32'h1);
        dmi_rd(DMI_ABSTRACTAUTO, rd); chk("abstractauto_absent", rd, 32'h0);
        dmi_wr(DMI_COMMAND, 32'h002A_1000);
        idle(6);
        chk("postinc_run0_ad", {16'b0, ar_ad_l}, 32'h0000_1000);
        dmi_rd(DMI_DATA0, rd);
        idle(6);
        chk("no_autoexec", ar_cnt, 32'd6);
`endif

        dmi_wr(DMI_DMCONTROL, 32'h0000_0000);
        chk("inactive_haltreq", {31'b0, HALTREQ}, 32'h0);
        dmi_rd(DMI_DATA0, rd); chk("inactive_data0", rd, 32'h0);
        dmi_rd(DMI_DATA1, rd); chk("inactive_data1", rd, 32'h0);
        dmi_wr(DMI_DATA0, 32'hFFFF_FFFF);
        dmi_rd(DMI_DATA0, rd); chk("inactive_data0_wr", rd, 32'h0);

        // Reset in the middle of a command drops AR_EN/AR_AD on the next cycle.
        dmi_wr(DMI_DMCONTROL, 32'h0000_0001);
        dmi_wr(DMI_COMMAND, 32'h0022_1008);
        chk("midcmd_ar_en", {31'b0, AR_EN}, 32'h1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("midrst_ar_en", {31'b0, AR_EN}, 32'h0);
        chk("midrst_ar_ad", {16'b0, AR_AD}, 32'h0);
        dmi_rd(DMI_ABSTRACTCS, rd); chk("midrst_abstractcs", rd, 32'h0000_0002);
        dmi_rd(DMI_DMCONTROL, rd);  chk("midrst_dmcontrol", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
